pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator; successor to the fixed 32-bit +4 program counter. It adds a reset vector, configurable width, 2/4-byte sequential step, a stall hold, prioritised trap and branch redirects, and an optional return-address stack (RAS) that predicts `ret` targets. It sits at the front of the fetch stage: it drives the instruction-memory address and supplies the link value to the writeback path.

## Interface
- `XLEN`, 32: PC and address width in bits, 16 or more.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset; bit 0 must be 0.
- `RAS_DEPTH`, 4: RAS entries; power of two, 2..16.
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous reset, active high.
- `stall_i` in 1: hold the current PC (pipeline back-pressure).
- `trap_i` in 1: take an exception or interrupt.
- `trap_pc_i` in XLEN: trap handler address.
- `redirect_i` in 1: resolved branch or jump from execute.
- `redirect_pc_i` in XLEN: branch or jump target.
- `compressed_i` in 1: the instruction at `pc_o` is 16-bit, so the step is 2; otherwise the step is 4.
- `ras_push_i` in 1: the instruction at `pc_o` is a call.
- `ras_pop_i` in 1: the instruction at `pc_o` is a return.
- `pc_o` out XLEN: current fetch PC.
- `pc_next_o` out XLEN: `pc_o` + step (2 or 4); the link value.
- `ras_hit_o` out 1: the next PC this cycle comes from the RAS top.

## Operation
- Next-PC selection, highest priority first:
  - reset loads `RESET_VECTOR`;
  - `trap_i` loads `trap_pc_i`;
  - `redirect_i` loads `redirect_pc_i`;
  - `stall_i` holds `pc_o`;
  - RAS pop with a non-empty stack loads the RAS top;
  - otherwise `pc_next_o` is loaded.
- Trap and redirect override stall.
- Bit 0 of every loaded target is forced to 0.
- Sequential arithmetic is modulo 2^XLEN. `pc_o` at all-ones minus 3 with step 4 wraps to 0; no flag is raised.
- "Advance" means none of reset, trap, redirect or stall is active. `ras_push_i` and `ras_pop_i` take effect only on an advance cycle and are ignored otherwise.
- RAS organisation:
  - circular buffer of XLEN-bit entries;
  - top pointer `tp`, plus occupancy `cnt` in 0..RAS_DEPTH.
- RAS operations on an advance cycle:
  - Push only: write `pc_next_o` at `tp+1`, advance `tp`, increment `cnt` saturating at RAS_DEPTH. A push when full overwrites the oldest entry.
  - Pop only with `cnt > 0`: the next PC is the top entry; `tp` moves back and `cnt` decrements.
  - Pop only with `cnt == 0`: no stack change; sequential step; `ras_hit_o` = 0.
  - Push and pop together (co-routine return): the next PC is the old top. The top entry is overwritten with `pc_next_o`; `tp` and `cnt` are unchanged. If `cnt == 0`, this behaves as push only.
- `trap_i` clears `cnt` to 0. Redirect leaves the RAS untouched (mispredicts are tolerated).
- `ras_hit_o` = advance & `ras_pop_i` & (`cnt > 0`). It is combinational.

## Timing
- `pc_o`, `tp` and `cnt` are registers; every selection takes effect on the next rising edge (1-cycle latency).
- `pc_next_o` and `ras_hit_o` are combinational from current state and inputs, in the same cycle.
- Reset state: `pc_o` = `RESET_VECTOR`, `pc_next_o` = `RESET_VECTOR` + step, `cnt` = 0, `tp` = 0, `ras_hit_o` = 0.
- `rst_i` asserted mid-operation wins over all other inputs at that edge. RAS entry contents need no reset.
- Continuous stall keeps `pc_o` constant indefinitely.

## Configuration
- Macro: `PC_GEN_RAS_EN`.
- Defined: the RAS is instantiated and behaves as described above.
- Undefined:
  - no RAS storage;
  - `ras_push_i` and `ras_pop_i` are ignored;
  - `ras_hit_o` is tied to 0;
  - the next-PC priority omits the RAS stage.
- Ports are identical in both builds.

## Structure
- Package `pc_pkg`:
  - `pc_sel_e` enum (`SEL_RESET`, `SEL_TRAP`, `SEL_REDIR`, `SEL_HOLD`, `SEL_RAS`, `SEL_SEQ`);
  - step constants `STEP_C` = 2 and `STEP_I` = 4.
- Sub-module `pc_ras`:
  - parameters `XLEN`, `RAS_DEPTH`;
  - ports for push, pop, push data, flush, top data and a non-empty flag;
  - instantiated only under `PC_GEN_RAS_EN`.

## Test plan
- Reset: `RESET_VECTOR` = 32'h0000_1000, `rst_i` held 2 cycles then released with no other inputs. Expected: `pc_o` = 1000, 1004, 1008 on successive cycles.
- Step and stall: `compressed_i` = 1 for 2 cycles, then `stall_i` for 3 cycles. Expected: `pc_o` goes 1000 → 1002 → 1004 and holds at 1004 for 3 cycles.
- Priority: trap, redirect and stall asserted together with `trap_pc_i` = 200 and `redirect_pc_i` = 301. Expected: `pc_o` = 200 next cycle; in a second run with redirect alone, `pc_o` = 300 (bit 0 cleared).
- RAS push and pop: push at `pc_o` = 40, then push at 80. A pop yields 84 with `ras_hit_o` = 1; the next pop yields 44; a third pop (empty) gives a sequential step with `ras_hit_o` = 0.
- RAS overflow and flush:
  - RAS_DEPTH + 1 pushes, then pops: the first RAS_DEPTH pops hit, the oldest entry is lost, and the next pop misses.
  - After a trap, a pop misses.
- Wrap and build: `pc_o` = 32'hFFFF_FFFC advancing with step 4 goes to 0. With `PC_GEN_RAS_EN` undefined, `ras_hit_o` stays 0 under the RAS push and pop scenario.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// The optional return-address stack is built only when PC_GEN_RAS_EN is defined.
package pc_pkg;

    // Source of the PC loaded at the next rising edge, highest priority first.
    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_TRAP  = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_HOLD  = 3'd3,
        SEL_RAS   = 3'd4,
        SEL_SEQ   = 3'd5
    } pc_sel_e;

    localparam int unsigned STEP_C = 2;
    localparam int unsigned STEP_I = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push stores a link at tp+1, pop exposes the top.
// When full, a push overwrites the oldest entry; flush only empties the occupancy.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   tp_q;
    logic [CW-1:0]   cnt_q;

    logic            do_push;
    logic            do_pop;
    logic            do_swap;
    logic [PW-1:0]   tp_inc;
    logic [PW-1:0]   tp_dec;

    assign valid_o = (cnt_q != '0);
    assign top_o   = mem_q[tp_q];
    assign tp_inc  = tp_q + 1'b1;
    assign tp_dec  = tp_q - 1'b1;

    // Push+pop on a non-empty stack replaces the top in place (co-routine return);
    // on an empty stack it degenerates to a plain push.
    assign do_push = push_i & ~(pop_i & valid_o);
    assign do_swap = push_i & pop_i & valid_o;
    assign do_pop  = pop_i & ~push_i & valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (do_push) begin
            tp_q <= tp_inc;
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            tp_q  <= tp_dec;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (do_push) begin
                mem_q[tp_inc] <= push_data_i;
            end else if (do_swap) begin
                mem_q[tp_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, 2/4-byte step, stall hold, trap/redirect redirects.
// Define PC_GEN_RAS_EN to add the return-address stack that predicts return targets.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            compressed_i,
    input  logic            ras_push_i,
    input  logic            ras_pop_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            ras_hit_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] target;
    logic            advance;
    logic [XLEN-1:0] ras_top;
    logic            ras_hit;
    pc_sel_e         sel;

    assign step      = compressed_i ? XLEN'(STEP_C) : XLEN'(STEP_I);
    assign pc_next_o = pc_q + step;
    assign pc_o      = pc_q;
    assign advance   = ~rst_i & ~trap_i & ~redirect_i & ~stall_i;

`ifdef PC_GEN_RAS_EN
    logic ras_valid;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (trap_i),
        .push_i      (advance & ras_push_i),
        .pop_i       (advance & ras_pop_i),
        .push_data_i (pc_next_o),
        .top_o       (ras_top),
        .valid_o     (ras_valid)
    );

    assign ras_hit = advance & ras_pop_i & ras_valid;
`else
    logic unused_ras;

    assign unused_ras = ^{ras_push_i, ras_pop_i, advance};
    assign ras_top    = '0;
    assign ras_hit    = 1'b0;
`endif

    assign ras_hit_o = ras_hit;

    always_comb begin
        sel = SEL_SEQ;
        if (rst_i) begin
            sel = SEL_RESET;
        end else if (trap_i) begin
            sel = SEL_TRAP;
        end else if (redirect_i) begin
            sel = SEL_REDIR;
        end else if (stall_i) begin
            sel = SEL_HOLD;
        end else if (ras_hit) begin
            sel = SEL_RAS;
        end
    end

    // Loaded targets are forced halfword aligned; sequential values already are.
    always_comb begin
        target = pc_next_o;
        case (sel)
            SEL_RESET: target = RESET_VECTOR;
            SEL_TRAP:  target = trap_pc_i;
            SEL_REDIR: target = redirect_pc_i;
            SEL_HOLD:  target = pc_q;
            SEL_RAS:   target = ras_top;
            default:   target = pc_next_o;
        endcase
        pc_d = {target[XLEN-1:1], 1'b0};
    end

    always_ff @(posedge clk_i) begin
        pc_q <= pc_d;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a
// queue-based reference model; adapts to builds with or without PC_GEN_RAS_EN.
module tb_pc_gen;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap;
    logic [31:0] trap_pc;
    logic        redir;
    logic [31:0] redir_pc;
    logic        comp;
    logic        push;
    logic        pop;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic        ras_hit_o;

    int checks = 0;
    int passes = 0;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .trap_i        (trap),
        .trap_pc_i     (trap_pc),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .compressed_i  (comp),
        .ras_push_i    (push),
        .ras_pop_i     (pop),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .ras_hit_o     (ras_hit_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end else begin
            passes++;
        end
    endtask

    // reference model: PC value plus the RAS as a queue (back = top)
    logic [31:0] m_pc;
    bit          m_valid = 0;
    logic [31:0] m_ras[$];

    always @(negedge clk) begin
        logic [31:0] seq;
        logic        adv;
        logic        hit;
        logic [31:0] nxt;
        #3;
        seq = m_pc + (comp ? 32'd2 : 32'd4);
        adv = !rst && !trap && !redir && !stall;
        hit = RAS_ON && adv && pop && (m_ras.size() > 0);
        if (m_valid) begin
            chk("pc_o", pc_o, m_pc);
            chk("pc_next_o", pc_next_o, seq);
            chk("ras_hit_o", {31'd0, ras_hit_o}, {31'd0, hit});
        end
        if (rst)        nxt = RV;
        else if (trap)  nxt = trap_pc & ~32'd1;
        else if (redir) nxt = redir_pc & ~32'd1;
        else if (stall) nxt = m_pc;
        else if (hit)   nxt = m_ras[m_ras.size()-1] & ~32'd1;
        else            nxt = seq;
        if (rst || trap) begin
            m_ras.delete();
        end else if (adv && RAS_ON) begin
            if (push && pop && m_ras.size() > 0) begin
                m_ras[m_ras.size()-1] = seq;
            end else if (push) begin
                m_ras.push_back(seq);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (pop && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        if (rst) m_valid = 1;
        m_pc = nxt;
    end

    // driver: inputs change at the falling edge and hold through the rising edge
    task automatic cyc(input logic r, input logic t, input logic rd, input logic s,
                       input logic c, input logic pu, input logic po,
                       input logic [31:0] tpc, input logic [31:0] rpc);
        @(negedge clk);
        rst = r; trap = t; redir = rd; stall = s; comp = c;
        push = pu; pop = po; trap_pc = tpc; redir_pc = rpc;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit_pc(input string name, input logic [31:0] exp);
        #4;
        chk(name, pc_o, exp);
    endtask

    task automatic lit_hit(input string name, input logic exp);
        #4;
        chk(name, {31'd0, ras_hit_o}, {31'd0, exp});
    endtask

    initial begin
        int hits;
        rst = 1; stall = 0; trap = 0; trap_pc = 0; redir = 0; redir_pc = 0;
        comp = 0; push = 0; pop = 0;

        // reset and sequential fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        lit_pc("reset_pc", RV);
        #0 chk("reset_next", pc_next_o, 32'h1004);
        lit_hit("reset_hit", 1'b0);
        idle(); lit_pc("seq_1000", 32'h1000);
        idle(); lit_pc("seq_1004", 32'h1004);
        idle(); lit_pc("seq_1008", 32'h1008);

        // compressed step then stall
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0); lit_pc("c_1000", 32'h1000);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0); lit_pc("c_1002", 32'h1002);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); lit_pc("stall0", 32'h1004);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); lit_pc("stall1", 32'h1004);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); lit_pc("stall2", 32'h1004);
        idle(); lit_pc("stall3", 32'h1004);

        // priority: trap over redirect over stall; redirect target aligned
        cyc(0, 1, 1, 1, 0, 0, 0, 32'h200, 32'h301);
        idle(); lit_pc("trap_pri", 32'h200);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 32'h301);
        idle(); lit_pc("redir_align", 32'h300);

        // RAS push at 40 and 80, then three pops
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0); lit_pc("push_at_40", 32'h40);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 32'h80);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0); lit_pc("push_at_80", 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit_hit("pop1_hit", RAS_ON);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit_pc("pop1_pc", RAS_ON ? 32'h84 : 32'h88);
        #0 chk("pop2_hit", {31'd0, ras_hit_o}, {31'd0, RAS_ON});
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit_pc("pop2_pc", RAS_ON ? 32'h44 : 32'h8c);
        #0 chk("pop3_hit", {31'd0, ras_hit_o}, 32'd0);
        idle(); lit_pc("pop3_seq", RAS_ON ? 32'h48 : 32'h90);

        // overflow: DEPTH+1 pushes, then DEPTH+1 pops
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        hits = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
            #4;
            if (ras_hit_o === 1'b1) hits++;
        end
        chk("overflow_hits", hits, RAS_ON ? DEPTH : 0);

        // trap empties the stack
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h500, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit_hit("pop_after_trap", 1'b0);

        // wrap at the top of the address space
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        idle(); lit_pc("wrap_pre", 32'hFFFF_FFFC);
        idle(); lit_pc("wrap_zero", 32'h0000_0000);

        // random traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom, $urandom);
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
